// File: rtl/bp_pkg.sv
// Shared types and widths for the branch prediction controller.
package bp_pkg;

    localparam int HIST_W      = 3;
    localparam int IDX_W       = 4;
    localparam int PC_W        = 10;
    localparam int DEF_QDEPTH  = 4;

    // One in-flight branch: its PC, the speculative history it was looked up
    // with, and the direction the tables predicted for it.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [HIST_W-1:0] snap;
        logic              pred;
    } bp_entry_t;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } bp_state_e;

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of predicted branches waiting for execute to resolve them.
// Flush wins over push and pop; a push while full is only taken together
// with a pop so the occupancy never exceeds DEPTH.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  bp_entry_t        push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output bp_entry_t        head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    bp_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Work out which transfers really happen and where the pointers go next.
    always_comb begin
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok) count_d = count_q + 1'b1;
            if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch prediction controller: tracks speculative and committed global
// history, the queue of unresolved predictions, the tag table that decides
// when a table entry must be evicted, and the one-cycle recovery after a
// mispredict. History, index and PC widths come from bp_pkg.
module branch_predict_ctrl
    import bp_pkg::*;
#(
    parameter int QDEPTH = DEF_QDEPTH
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic              fetch_ready,
    output logic              pred_taken,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    output logic              mispredict,
    output logic              resolve_err,
    output logic [PC_W-1:0]   tbl_pc,
    output logic [HIST_W-1:0] tbl_prev_history,
    input  logic              tbl_prediction,
    output logic              tbl_evict,
    output logic              tbl_we,
    output logic [PC_W-1:0]   tbl_old_pc,
    output logic [HIST_W-1:0] tbl_update_history,
    output logic              tbl_branch_taken
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;
    localparam int TAG_W = PC_W - IDX_W;
    localparam int TBL_N = 1 << IDX_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

    bp_state_e         state_q, state_d;
    logic [HIST_W-1:0] spec_ghr_q, spec_ghr_d;
    logic [HIST_W-1:0] commit_ghr_q, commit_ghr_d;
    logic              tag_valid_q [TBL_N];
    logic [TAG_W-1:0]  tag_q [TBL_N];

    logic              tbl_we_q;
    logic [PC_W-1:0]   tbl_old_pc_q;
    logic [HIST_W-1:0] tbl_update_history_q;
    logic              tbl_branch_taken_q;

    bp_entry_t         head_entry, push_entry;
    logic [CNT_W-1:0]  count;
    logic              full, empty;
    logic              push, pop;
    logic [IDX_W-1:0]  fetch_idx;
    logic [TAG_W-1:0]  fetch_tag;

    assign fetch_idx          = fetch_pc[IDX_W-1:0];
    assign fetch_tag          = fetch_pc[PC_W-1:IDX_W];
    assign tbl_pc             = fetch_pc;
    assign tbl_prev_history   = spec_ghr_q;
    assign pred_taken         = tbl_prediction;
    assign push_entry         = '{pc: fetch_pc, snap: spec_ghr_q, pred: tbl_prediction};
    assign tbl_we             = tbl_we_q;
    assign tbl_old_pc         = tbl_old_pc_q;
    assign tbl_update_history = tbl_update_history_q;
    assign tbl_branch_taken   = tbl_branch_taken_q;

    // Handshake decisions for this cycle: a mispredict blocks fetch so the
    // flushed queue never receives a wrong-path branch, and a full queue only
    // accepts when the head is leaving in the same cycle.
    always_comb begin
        pop         = resolve_valid && !empty;
        resolve_err = resolve_valid && empty;
        mispredict  = pop && (resolve_taken != head_entry.pred);
        fetch_ready = (state_q == RUN) && !mispredict &&
                      ((count < DEPTH_C) || (resolve_valid && full));
        push        = fetch_valid && fetch_ready;
        tbl_evict   = push && (!tag_valid_q[fetch_idx] || (tag_q[fetch_idx] != fetch_tag));
    end

    // Next FSM state and histories; recovery rebuilds speculative history
    // from the mispredicted branch's snapshot plus its real outcome.
    always_comb begin
        state_d      = mispredict ? RECOVER : RUN;
        spec_ghr_d   = spec_ghr_q;
        commit_ghr_d = commit_ghr_q;
        if (mispredict) begin
            spec_ghr_d = {head_entry.snap[HIST_W-2:0], resolve_taken};
        end else if (push) begin
            spec_ghr_d = {spec_ghr_q[HIST_W-2:0], tbl_prediction};
        end
        if (pop) begin
            commit_ghr_d = {commit_ghr_q[HIST_W-2:0], resolve_taken};
        end
    end

    // FSM and global history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            spec_ghr_q   <= '0;
            commit_ghr_q <= '0;
        end else begin
            state_q      <= state_d;
            spec_ghr_q   <= spec_ghr_d;
            commit_ghr_q <= commit_ghr_d;
        end
    end

    // Tag table: remember which PC currently owns each table index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TBL_N; i++) begin
                tag_valid_q[i] <= 1'b0;
                tag_q[i]       <= '0;
            end
        end else if (push) begin
            tag_valid_q[fetch_idx] <= 1'b1;
            tag_q[fetch_idx]       <= fetch_tag;
        end
    end

    // Table update strobe and payload, one cycle after the head resolves.
    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_we_q             <= 1'b0;
            tbl_old_pc_q         <= '0;
            tbl_update_history_q <= '0;
            tbl_branch_taken_q   <= 1'b0;
        end else begin
            tbl_we_q <= pop;
            if (pop) begin
                tbl_old_pc_q         <= head_entry.pc;
                tbl_update_history_q <= head_entry.snap;
                tbl_branch_taken_q   <= resolve_taken;
            end
        end
    end

    // Every older branch has resolved correctly, so the oldest in-flight
    // snapshot (or the speculative history when idle) equals committed history.
    assert property (@(posedge clk) disable iff (rst)
        (empty ? (spec_ghr_q == commit_ghr_q) : (head_entry.snap == commit_ghr_q)));

    bp_inflight_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (mispredict),
        .head_o      (head_entry),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: the driver runs a queue-based
// reference model and posts expected per-cycle outputs and expected table
// updates; a monitor compares them against the DUT on the falling edge.
module tb_branch_predict_ctrl;

    localparam int QD = 4;
    localparam int HW = 3;
    localparam int IW = 4;
    localparam int PW = 10;

    logic          clk, rst;
    logic          fetch_valid;
    logic [PW-1:0] fetch_pc;
    logic          fetch_ready, pred_taken;
    logic          resolve_valid, resolve_taken;
    logic          mispredict, resolve_err;
    logic [PW-1:0] tbl_pc;
    logic [HW-1:0] tbl_prev_history;
    logic          tbl_prediction, tbl_evict, tbl_we;
    logic [PW-1:0] tbl_old_pc;
    logic [HW-1:0] tbl_update_history;
    logic          tbl_branch_taken;

    branch_predict_ctrl #(.QDEPTH(QD)) dut (
        .clk                (clk),
        .rst                (rst),
        .fetch_valid        (fetch_valid),
        .fetch_pc           (fetch_pc),
        .fetch_ready        (fetch_ready),
        .pred_taken         (pred_taken),
        .resolve_valid      (resolve_valid),
        .resolve_taken      (resolve_taken),
        .mispredict         (mispredict),
        .resolve_err        (resolve_err),
        .tbl_pc             (tbl_pc),
        .tbl_prev_history   (tbl_prev_history),
        .tbl_prediction     (tbl_prediction),
        .tbl_evict          (tbl_evict),
        .tbl_we             (tbl_we),
        .tbl_old_pc         (tbl_old_pc),
        .tbl_update_history (tbl_update_history),
        .tbl_branch_taken   (tbl_branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            comb;
        bit            ready, evict, mis, err, pred, we, regsZero;
        logic [HW-1:0] hist;
        logic [PW-1:0] pc;
    } cycExp_t;

    typedef struct {
        logic [PW-1:0] pc;
        logic [HW-1:0] hist;
        bit            taken;
    } updExp_t;

    typedef struct {
        logic [PW-1:0] pc;
        int            snap;
        bit            pred;
    } inflight_t;

    cycExp_t   cycQ[$];
    updExp_t   updQ[$];
    inflight_t modelQ[$];
    int        specHist;
    bit        inRecover;
    bit        tagSeen[1 << IW];
    int        tagHeld[1 << IW];
    bit        nextWe, nextZero;
    int        total, bad;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and advance the reference model by one cycle.
    task automatic applyStimulus(input bit r, input bit fv, input logic [PW-1:0] pc,
                                 input bit tp, input bit rv, input bit rt);
        cycExp_t e;
        int cnt, idx, tag;
        bit pop, mis, rdy, psh;
        @(posedge clk);
        #1;
        rst            = r;
        fetch_valid    = fv;
        fetch_pc       = pc;
        tbl_prediction = tp;
        resolve_valid  = rv;
        resolve_taken  = rt;
        e          = '{default: 0};
        e.pc       = pc;
        e.pred     = tp;
        e.we       = nextWe;
        e.regsZero = nextZero;
        if (r) begin
            modelQ.delete();
            specHist  = 0;
            inRecover = 0;
            foreach (tagSeen[i]) tagSeen[i] = 0;
            nextWe    = 0;
            nextZero  = 1;
            e.comb    = 0;
        end else begin
            cnt = modelQ.size();
            pop = rv && (cnt > 0);
            mis = 0;
            if (pop) mis = (rt != modelQ[0].pred);
            rdy = !inRecover && !mis && ((cnt < QD) || (rv && cnt == QD));
            psh = fv && rdy;
            idx = int'(pc) % (1 << IW);
            tag = int'(pc) / (1 << IW);
            e.comb  = 1;
            e.ready = rdy;
            e.evict = psh && (!tagSeen[idx] || tagHeld[idx] != tag);
            e.mis   = mis;
            e.err   = rv && (cnt == 0);
            e.hist  = HW'(specHist);
            nextWe   = pop;
            nextZero = 0;
            if (pop) updQ.push_back('{pc: modelQ[0].pc, hist: HW'(modelQ[0].snap), taken: rt});
            if (mis) begin
                specHist  = (modelQ[0].snap * 2 + int'(rt)) % (1 << HW);
                modelQ.delete();
                inRecover = 1;
            end else begin
                inRecover = 0;
                if (pop) void'(modelQ.pop_front());
                if (psh) begin
                    modelQ.push_back('{pc: pc, snap: specHist, pred: tp});
                    specHist     = (specHist * 2 + int'(tp)) % (1 << HW);
                    tagSeen[idx] = 1;
                    tagHeld[idx] = tag;
                end
            end
        end
        cycQ.push_back(e);
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, '0, 0, 0, 0);
    endtask

    task automatic doReset();
        applyStimulus(1, 0, '0, 0, 0, 0);
    endtask

    cycExp_t mon;
    updExp_t upd;

    // Monitor: compare per-cycle outputs and every table update strobe.
    always @(negedge clk) begin
        if (cycQ.size() > 0) begin
            mon = cycQ.pop_front();
            if (mon.comb) begin
                checkOutput("fetch_ready", fetch_ready, mon.ready);
                checkOutput("tbl_evict", tbl_evict, mon.evict);
                checkOutput("mispredict", mispredict, mon.mis);
                checkOutput("resolve_err", resolve_err, mon.err);
                checkOutput("pred_taken", pred_taken, mon.pred);
                checkOutput("tbl_prev_history", tbl_prev_history, mon.hist);
                checkOutput("tbl_pc", tbl_pc, mon.pc);
            end
            checkOutput("tbl_we", tbl_we, mon.we);
            if (mon.regsZero) begin
                checkOutput("rst_old_pc", tbl_old_pc, 0);
                checkOutput("rst_upd_hist", tbl_update_history, 0);
                checkOutput("rst_taken", tbl_branch_taken, 0);
            end
        end
        if (tbl_we === 1'b1) begin
            if (updQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL upd_unexpected actual=tbl_we 1 expected=no pending update at %0t", $time);
            end else begin
                upd = updQ.pop_front();
                checkOutput("upd_old_pc", tbl_old_pc, upd.pc);
                checkOutput("upd_history", tbl_update_history, upd.hist);
                checkOutput("upd_taken", tbl_branch_taken, upd.taken);
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit fv, tp, rv, rt, r;
        logic [PW-1:0] pc;
        rst = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; tbl_prediction = 1'b0;
        resolve_valid = 1'b0; resolve_taken = 1'b0;
        total = 0; bad = 0; specHist = 0; inRecover = 0; nextWe = 0; nextZero = 1;
        foreach (tagSeen[i]) begin tagSeen[i] = 0; tagHeld[i] = 0; end

        // Reset then idle
        doReset(); doReset();
        repeat (3) idleCycle();

        // Single branch, correct resolve two cycles later
        applyStimulus(0, 1, 10'h013, 1, 0, 0);
        idleCycle();
        applyStimulus(0, 0, '0, 0, 1, 1);
        idleCycle(); idleCycle();

        // Three predictions, first one mispredicted, fetch tries during recovery
        doReset();
        applyStimulus(0, 1, 10'h101, 1, 0, 0);
        applyStimulus(0, 1, 10'h102, 1, 0, 0);
        applyStimulus(0, 1, 10'h103, 0, 0, 0);
        applyStimulus(0, 1, 10'h104, 1, 1, 0);
        applyStimulus(0, 1, 10'h105, 1, 0, 0);
        applyStimulus(0, 1, 10'h106, 0, 0, 0);
        idleCycle();

        // Fill the queue, then push together with a correct resolve
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 10'h040 + 10'(i), 1, 0, 0);
        applyStimulus(0, 1, 10'h050, 1, 0, 0);
        applyStimulus(0, 1, 10'h051, 1, 1, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 0, 1, 1);
        idleCycle();

        // Tag conflicts on index 3
        doReset();
        applyStimulus(0, 1, 10'h023, 0, 0, 0);
        applyStimulus(0, 1, 10'h003, 1, 0, 0);
        applyStimulus(0, 1, 10'h003, 0, 0, 0);
        idleCycle();

        // Resolve on empty queue, then reset with branches in flight
        doReset();
        applyStimulus(0, 0, '0, 0, 1, 1);
        idleCycle();
        applyStimulus(0, 1, 10'h077, 1, 0, 0);
        applyStimulus(0, 1, 10'h078, 0, 0, 0);
        applyStimulus(1, 1, 10'h079, 1, 1, 1);
        idleCycle(); idleCycle();

        // Randomized traffic
        repeat (3000) begin
            r  = ($urandom_range(0, 99) == 0);
            fv = ($urandom_range(0, 99) < 65);
            pc = 10'($urandom_range(0, 2) * 64 + $urandom_range(0, 15));
            tp = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 99) < 45);
            if (modelQ.size() > 0 && $urandom_range(0, 99) < 85) rt = modelQ[0].pred;
            else rt = 1'($urandom_range(0, 1));
            applyStimulus(r, fv, pc, tp, rv, rt);
        end
        repeat (3) idleCycle();
        @(negedge clk);
        @(negedge clk);
        checkOutput("cyc_drain", cycQ.size(), 0);
        checkOutput("upd_drain", updQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
Sequences the per-PC two-level prediction tables for the pipelined core. Maintains the speculative and committed 3-bit global history and a small in-order queue of in-flight branch predictions. Drives the tables' lookup, update and evict controls, and raises flush/recovery when execute resolves a mispredicted branch. Sits between fetch (lookup side), execute (resolve side) and the prediction tables.

Parameters:
QDEPTH, 4, in-flight branch queue depth (power of two, ≥2)
HIST_W, 3, global history width (matches table history address)
IDX_W, 4, table index bits taken from pc[IDX_W-1:0]
PC_W, 10, program counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
fetch_valid  in  1  fetch presents a branch at fetch_pc this cycle
fetch_pc  in  PC_W  PC of the fetched branch
fetch_ready  out  1  controller accepts the branch this cycle
pred_taken  out  1  prediction returned to fetch; equals tbl_prediction
resolve_valid  in  1  execute resolves the oldest in-flight branch
resolve_taken  in  1  actual branch outcome
mispredict  out  1  one-cycle pulse: flush the younger pipeline
resolve_err  out  1  one-cycle pulse: resolve while the queue is empty
tbl_pc  out  PC_W  lookup PC; combinational copy of fetch_pc
tbl_prev_history  out  HIST_W  lookup history; the speculative GHR register
tbl_prediction  in  1  prediction bit from the tables
tbl_evict  out  1  clear the entry at tbl_pc (tag miss)
tbl_we  out  1  registered table update strobe
tbl_old_pc  out  PC_W  registered PC being updated
tbl_update_history  out  HIST_W  registered history snapshot for the update
tbl_branch_taken  out  1  registered outcome for the update

Behaviour:
- Reset, synchronous: state=RUN; queue empty (head=tail=0, count=0); spec_ghr=0; commit_ghr=0; all tag valid bits=0.
  - Every registered output is 0 after reset.
  - fetch_ready=1 in the first cycle after reset.
  - rst overrides every other event in the same cycle.
- FSM has two states, RUN and RECOVER.
  - RUN: fetch_ready = (count<QDEPTH) OR (resolve_valid AND count==QDEPTH AND no mispredict this cycle).
  - RECOVER: lasts exactly 1 cycle. fetch_ready=0, no push, no tbl_evict. Next state is RUN.
  - resolve_valid is still honoured in RECOVER.
- Push on fetch_valid & fetch_ready:
  - Queue entry gets {pc, snap=spec_ghr, pred=tbl_prediction}.
  - spec_ghr <= {spec_ghr[HIST_W-2:0], tbl_prediction}.
  - pred_taken is valid in the same cycle as the push; lookup latency is 0.
- Tag table: QDEPTH-independent, 2^IDX_W entries of {valid, pc[PC_W-1:IDX_W]}.
  - On push, if the indexed entry is invalid or its tag differs: tbl_evict=1 that cycle (combinational), and the tag is written with valid=1.
  - On evict, pred_taken still reflects the pre-clear table value.
- Pop on resolve_valid with count>0:
  - Next cycle: tbl_we=1, tbl_old_pc=entry.pc, tbl_update_history=entry.snap, tbl_branch_taken=resolve_taken.
  - commit_ghr <= {commit_ghr[HIST_W-2:0], resolve_taken}.
- Mispredict is resolve_taken != entry.pred.
  - The mispredict pulse is combinational in the resolve cycle.
  - Next cycle: queue cleared (count=0, head=tail), spec_ghr <= {entry.snap[HIST_W-2:0], resolve_taken}, state <= RECOVER.
  - A push in the same cycle is dropped; fetch_ready is forced to 0 that cycle.
- resolve_valid with count==0: no pop, no tbl_we, resolve_err=1 for 1 cycle, GHRs unchanged.
- Simultaneous push and correct pop: count is unchanged and both pointers advance. This is legal when full.
- Pointers wrap modulo QDEPTH. count has width clog2(QDEPTH)+1 and never exceeds QDEPTH.

Decomposition:
- Shared package bp_pkg holds:
  - bp_entry_t {pc, snap, pred}
  - HIST_W, PC_W, IDX_W constants
  - bp_state_e {RUN, RECOVER}
- One sub-module, bp_inflight_fifo: a synchronous FIFO of bp_entry_t with push, pop, flush, count, full and empty.
- Tag table, GHRs and FSM live in the top module.

Test Plan:
1. Reset, then idle for 3 cycles -> fetch_ready=1, tbl_we=0, mispredict=0, tbl_prev_history=0.
2. Push pc=0x013 with tbl_prediction=1; resolve taken=1 two cycles later -> tbl_evict=1 in the push cycle; spec_ghr=3'b001; one cycle after resolve, tbl_we=1, tbl_old_pc=0x013, tbl_update_history=0, tbl_branch_taken=1; mispredict=0.
3. Push 3 branches with preds 1,1,0 (spec_ghr=3'b110); resolve the first with taken=0 -> mispredict=1; next cycle count=0, spec_ghr=3'b000, fetch_ready=0 for exactly 1 cycle, then 1.
4. Push 4 branches with no resolves -> fetch_ready=0 at count=4. Assert fetch_valid together with a correct resolve -> push is accepted and count stays 4.
5. Push pc=0x023, then pc=0x003 (same index 3, different tag) -> tbl_evict=1 on both pushes. Push pc=0x003 again -> tbl_evict=0.
6. resolve_valid with an empty queue -> resolve_err=1 for 1 cycle, tbl_we=0, GHRs unchanged. Assert rst while the queue is non-empty -> count=0 and all outputs 0 on the next cycle.
